vgalcd_pixfetch: RTL and testbench

VGALCD_PIXFETCH -- requirements
Module: vgalcd_pixfetch

---
 rtl/vgalcd_pixfetch_pkg.sv | 15 +
 rtl/vgalcd_pixfetch_if.sv | 11 +
 rtl/vgalcd_dff.sv | 29 ++
 rtl/vgalcd_wfifo.sv | 54 +++++
 rtl/vgalcd_pixfetch.sv | 84 ++++++++
 tb/tb_vgalcd_pixfetch.sv | 227 ++++++++++++++++++++++
 6 files changed

// File: rtl/vgalcd_pixfetch_pkg.sv
// rtl/vgalcd_pixfetch_pkg.sv - shared colour-mode encodings and pixels-per-word helper
package vgalcd_pixfetch_pkg;

    typedef enum logic [1:0] {
        MODE_RGB332 = 2'd0,
        MODE_RGB444 = 2'd1,
        MODE_RGB555 = 2'd2,
        MODE_RGB565 = 2'd3
    } vgalcd_mode_e;

    function automatic int unsigned pix_per_word(input vgalcd_mode_e mode, input int unsigned data_width);
        return (mode == MODE_RGB332) ? data_width / 8 : data_width / 16;
    endfunction

endpackage

// File: rtl/vgalcd_pixfetch_if.sv
// rtl/vgalcd_pixfetch_if.sv - bus-side word handshake into the pixel fetcher
interface vgalcd_pixfetch_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  pixel_valid_i;
    logic                  pixel_ready_o;
    logic [DATA_WIDTH-1:0] pixel_data_i;

    modport master (output pixel_valid_i, output pixel_data_i, input pixel_ready_o);
    modport slave  (input pixel_valid_i, input pixel_data_i, output pixel_ready_o);
endinterface

// File: rtl/vgalcd_dff.sv
// rtl/vgalcd_dff.sv - flop primitives with async active-low reset to zero
module dffr #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) q_o <= '0;
        else          q_o <= d_i;
    end
endmodule

module dffer #(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)  q_o <= '0;
        else if (en_i) q_o <= d_i;
    end
endmodule

// File: rtl/vgalcd_wfifo.sv
// rtl/vgalcd_wfifo.sv - bus word FIFO with separate count; clear wins over push/pop
module vgalcd_wfifo #(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          clr_i,
    input  logic                          push_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    input  logic                          pop_i,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_d;
    logic                  do_push, do_pop;

    assign full_o  = (count_o == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_o == '0);
    assign do_push = push_i && !full_o && !clr_i;
    assign do_pop  = pop_i && !empty_o && !clr_i;
    assign rdata_o = mem[rd_ptr];

    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        cnt_d    = count_o;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr + PTR_W'(1);
            cnt_d = count_o + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage is deliberately left without reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= wdata_i;
    end

    dffr #(.W(PTR_W)) u_wr_ptr (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(wr_ptr_d), .q_o(wr_ptr));
    dffr #(.W(PTR_W)) u_rd_ptr (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(rd_ptr_d), .q_o(rd_ptr));
    dffr #(.W(CNT_W)) u_count  (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(cnt_d),    .q_o(count_o));
endmodule

// File: rtl/vgalcd_pixfetch.sv
// rtl/vgalcd_pixfetch.sv - buffers bus words and unpacks them into one pixel per pixel-clock slot
module vgalcd_pixfetch
    import vgalcd_pixfetch_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        en_i,
    input  logic                        flush_i,
    input  logic [1:0]                  mode_i,
    input  logic                        pclk_en_i,
    input  logic                        de_i,
    vgalcd_pixfetch_if.slave            bus,
    output logic [15:0]                 pix_o,
    output logic                        pix_vld_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt_o,
    output logic                        underflow_o,
    input  logic                        underflow_clr_i
);
    localparam int LANE_W = $clog2(DATA_WIDTH / 8);

    logic [DATA_WIDTH-1:0] head;
    logic                  full, empty;
    logic                  flush_all, push, pop, slot, uf_slot, lane_last;
    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [15:0]           lane_pix, pix_d;
    logic                  pix_en, vld_d, uf_d;

    assign flush_all = flush_i || !en_i;
    // Reset gates ready combinationally so it drops the instant reset asserts.
    assign bus.pixel_ready_o = rst_n_i && en_i && !flush_i && !full;
    assign push      = bus.pixel_valid_i && bus.pixel_ready_o;
    assign slot      = pclk_en_i && de_i && en_i;
    assign uf_slot   = slot && empty;
    assign lane_last = (lane_q == LANE_W'(pix_per_word(vgalcd_mode_e'(mode_i), DATA_WIDTH) - 1));
    assign pop       = slot && !empty && lane_last && !flush_all;

    always_comb begin
        lane_pix = '0;
        for (int i = 0; i < DATA_WIDTH / 8; i++)
            if (mode_i == MODE_RGB332 && lane_q == LANE_W'(i)) lane_pix = {8'h00, head[i*8 +: 8]};
        for (int i = 0; i < DATA_WIDTH / 16; i++)
            if (mode_i != MODE_RGB332 && lane_q == LANE_W'(i)) lane_pix = head[i*16 +: 16];
    end

    always_comb begin
        pix_en = flush_all || slot;
        pix_d  = '0;
        lane_d = lane_q;
        vld_d  = slot && !flush_all;
        uf_d   = underflow_o;
        if (flush_all) begin
            lane_d = '0;
        end else if (slot && !empty) begin
            pix_d  = lane_pix;
            lane_d = lane_last ? '0 : lane_q + LANE_W'(1);
        end
        if (underflow_clr_i)          uf_d = 1'b0;
        if (uf_slot && !flush_all)    uf_d = 1'b1;
    end

    vgalcd_wfifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_wfifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (flush_all),
        .push_i  (push),
        .wdata_i (bus.pixel_data_i),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_cnt_o)
    );

    dffer #(.W(LANE_W)) u_lane (.clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(pix_en), .d_i(lane_d), .q_o(lane_q));
    dffer #(.W(16))     u_pix  (.clk_i(clk_i), .rst_n_i(rst_n_i), .en_i(pix_en), .d_i(pix_d),  .q_o(pix_o));
    dffr  #(.W(1))      u_vld  (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(vld_d), .q_o(pix_vld_o));
    dffr  #(.W(1))      u_uf   (.clk_i(clk_i), .rst_n_i(rst_n_i), .d_i(uf_d),  .q_o(underflow_o));
endmodule

// File: tb/tb_vgalcd_pixfetch.sv
// tb/tb_vgalcd_pixfetch.sv - directed vector bench for vgalcd_pixfetch at 64- and 32-bit widths
module tb_vgalcd_pixfetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        en, flush, pclk, de, uclr;
    logic [1:0]  mode;
    logic [15:0] pix;
    logic        vld, uf;
    logic [2:0]  cnt;

    logic        en32, flush32, pclk32, de32, uclr32;
    logic [1:0]  mode32;
    logic [15:0] pix32;
    logic        vld32, uf32;
    logic [2:0]  cnt32;

    vgalcd_pixfetch_if #(.DATA_WIDTH(64)) bus64 ();
    vgalcd_pixfetch_if #(.DATA_WIDTH(32)) bus32 ();

    vgalcd_pixfetch #(.DATA_WIDTH(64), .FIFO_DEPTH(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .flush_i(flush), .mode_i(mode),
        .pclk_en_i(pclk), .de_i(de), .bus(bus64), .pix_o(pix), .pix_vld_o(vld),
        .fifo_cnt_o(cnt), .underflow_o(uf), .underflow_clr_i(uclr)
    );

    vgalcd_pixfetch #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en32), .flush_i(flush32), .mode_i(mode32),
        .pclk_en_i(pclk32), .de_i(de32), .bus(bus32), .pix_o(pix32), .pix_vld_o(vld32),
        .fifo_cnt_o(cnt32), .underflow_o(uf32), .underflow_clr_i(uclr32)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] word;
        int          n;
        logic [15:0] exp [8];
    } vec_t;

    vec_t tbl [4];
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl[0].mode = 2'd3; tbl[0].word = 64'h4444_3333_2222_1111; tbl[0].n = 4;
        tbl[0].exp  = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
        tbl[1].mode = 2'd0; tbl[1].word = 64'h8877_6655_4433_2211; tbl[1].n = 8;
        tbl[1].exp  = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066, 16'h0077, 16'h0088};
        tbl[2].mode = 2'd1; tbl[2].word = 64'hFEDC_BA98_7654_3210; tbl[2].n = 4;
        tbl[2].exp  = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'h0, 16'h0, 16'h0, 16'h0};
        tbl[3].mode = 2'd0; tbl[3].word = 64'h0123_4567_89AB_CDEF; tbl[3].n = 8;
        tbl[3].exp  = '{16'h00EF, 16'h00CD, 16'h00AB, 16'h0089, 16'h0067, 16'h0045, 16'h0023, 16'h0001};

        rst_n = 1'b0;
        en = 1'b1; flush = 1'b0; mode = 2'd3; pclk = 1'b0; de = 1'b1; uclr = 1'b0;
        bus64.pixel_valid_i = 1'b0; bus64.pixel_data_i = '0;
        en32 = 1'b1; flush32 = 1'b0; mode32 = 2'd3; pclk32 = 1'b0; de32 = 1'b1; uclr32 = 1'b0;
        bus32.pixel_valid_i = 1'b0; bus32.pixel_data_i = '0;

        #12;
        chk("rst_ready", bus64.pixel_ready_o, 0);
        chk("rst_pix", pix, 0);
        chk("rst_vld", vld, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_uf", uf, 0);
        chk("rst_lane", dut.lane_q, 0);
        chk("rst_ready32", bus32.pixel_ready_o, 0);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", bus64.pixel_ready_o, 1);

        // 32-bit instance: fill to full, then one pop lets exactly one more word in
        bus32.pixel_valid_i = 1'b1; bus32.pixel_data_i = 32'h2222_1111;
        repeat (6) tick();
        chk("w32_full_cnt", cnt32, 4);
        chk("w32_full_ready", bus32.pixel_ready_o, 0);
        pclk32 = 1'b1;
        tick();
        chk("w32_pix0", pix32, 16'h1111);
        chk("w32_cnt_mid", cnt32, 4);
        tick();
        pclk32 = 1'b0;
        chk("w32_pix1", pix32, 16'h2222);
        chk("w32_cnt_pop", cnt32, 3);
        chk("w32_ready_pop", bus32.pixel_ready_o, 1);
        tick();
        chk("w32_cnt_refill", cnt32, 4);
        chk("w32_ready_refill", bus32.pixel_ready_o, 0);
        bus32.pixel_valid_i = 1'b0;

        for (int v = 0; v < 4; v++) begin
            en = 1'b0; mode = tbl[v].mode;
            tick();
            en = 1'b1;
            bus64.pixel_valid_i = 1'b1; bus64.pixel_data_i = tbl[v].word;
            tick();
            bus64.pixel_valid_i = 1'b0;
            chk($sformatf("v%0d_cnt_push", v), cnt, 1);
            for (int i = 0; i < tbl[v].n; i++) begin
                pclk = 1'b1;
                tick();
                chk($sformatf("v%0d_pix%0d", v, i), pix, tbl[v].exp[i]);
                chk($sformatf("v%0d_vld%0d", v, i), vld, 1);
                chk($sformatf("v%0d_cnt%0d", v, i), cnt, (i == tbl[v].n - 1) ? 0 : 1);
            end
            pclk = 1'b0;
            tick();
            chk($sformatf("v%0d_vld_idle", v), vld, 0);
        end

        // push and pop in the same cycle
        en = 1'b0; mode = 2'd3;
        tick();
        en = 1'b1;
        bus64.pixel_valid_i = 1'b1; bus64.pixel_data_i = 64'h4444_3333_2222_1111;
        tick();
        bus64.pixel_valid_i = 1'b0;
        pclk = 1'b1;
        repeat (3) tick();
        bus64.pixel_valid_i = 1'b1; bus64.pixel_data_i = 64'hDDDD_CCCC_BBBB_AAAA;
        tick();
        bus64.pixel_valid_i = 1'b0; pclk = 1'b0;
        chk("pp_pix", pix, 16'h4444);
        chk("pp_cnt", cnt, 1);
        pclk = 1'b1;
        tick();
        pclk = 1'b0;
        chk("pp_next_pix", pix, 16'hAAAA);
        chk("pp_next_lane", dut.lane_q, 1);

        // de low: no slot, pixel holds
        pclk = 1'b1; de = 1'b0;
        tick();
        chk("de0_pix", pix, 16'hAAAA);
        chk("de0_vld", vld, 0);
        chk("de0_lane", dut.lane_q, 1);
        chk("de0_cnt", cnt, 1);
        de = 1'b1;
        tick();
        pclk = 1'b0;
        chk("pre_flush_pix", pix, 16'hBBBB);

        // flush mid-word, with a push attempt in the same cycle
        flush = 1'b1; bus64.pixel_valid_i = 1'b1; bus64.pixel_data_i = 64'h9999_9999_9999_9999;
        #1;
        chk("flush_ready", bus64.pixel_ready_o, 0);
        tick();
        flush = 1'b0; bus64.pixel_valid_i = 1'b0;
        chk("flush_cnt", cnt, 0);
        chk("flush_pix", pix, 0);
        chk("flush_lane", dut.lane_q, 0);
        chk("flush_uf", uf, 0);

        // underflow, then clear colliding with a fresh underflow
        pclk = 1'b1;
        tick();
        chk("uf_pix", pix, 0);
        chk("uf_vld", vld, 1);
        chk("uf_set", uf, 1);
        chk("uf_lane", dut.lane_q, 0);
        uclr = 1'b1;
        tick();
        pclk = 1'b0; uclr = 1'b0;
        chk("uf_set_wins", uf, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("uf_survives_flush", uf, 1);
        uclr = 1'b1;
        tick();
        uclr = 1'b0;
        chk("uf_cleared", uf, 0);

        // push into empty FIFO with a slot in the same cycle is an underflow
        bus64.pixel_valid_i = 1'b1; bus64.pixel_data_i = 64'h4444_3333_2222_1111; pclk = 1'b1;
        tick();
        bus64.pixel_valid_i = 1'b0;
        chk("nobypass_uf", uf, 1);
        chk("nobypass_pix", pix, 0);
        chk("nobypass_cnt", cnt, 1);
        chk("nobypass_lane", dut.lane_q, 0);
        tick();
        pclk = 1'b0;
        chk("after_flush_lane0", pix, 16'h1111);

        // asynchronous reset in the middle of a word
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_pix", pix, 0);
        chk("arst_vld", vld, 0);
        chk("arst_cnt", cnt, 0);
        chk("arst_uf", uf, 0);
        chk("arst_ready", bus64.pixel_ready_o, 0);
        chk("arst_lane", dut.lane_q, 0);
        #3;
        rst_n = 1'b1;
        tick();
        bus64.pixel_valid_i = 1'b1; bus64.pixel_data_i = 64'h8888_7777_6666_5555;
        tick();
        bus64.pixel_valid_i = 1'b0; pclk = 1'b1;
        tick();
        pclk = 1'b0;
        chk("arst_first_pix", pix, 16'h5555);
        chk("arst_first_cnt", cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
